// File: rtl/demux_1x8_32_buf.sv
// rtl/demux_1x8_32_buf.sv - 1-to-8 word distributor with a one-word holding buffer per channel
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   d            input data word
//   s2, s1, s0   destination select {s2,s1,s0}, s2 is MSB
//   in_valid     d and select are valid this cycle
//   in_ready     selected channel can take a word this cycle (combinational)
//   op0 .. op7   per-channel data registers
//   v            per-channel "holds an unconsumed word" flags
//   ack          per-channel consume strobes, ignored where v is clear
//   pending      registered popcount of v

module demux_1x8_32_buf #(
    parameter int WIDTH = 32,
    parameter int NCH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] op0,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] op3,
    output logic [WIDTH-1:0] op4,
    output logic [WIDTH-1:0] op5,
    output logic [WIDTH-1:0] op6,
    output logic [WIDTH-1:0] op7,
    output logic [NCH-1:0]   v,
    input  logic [NCH-1:0]   ack,
    output logic [3:0]       pending
);

    logic [2:0]       sel;
    logic             accept;
    logic [NCH-1:0]   wr_en;
    logic [NCH-1:0]   drain;
    logic [NCH-1:0]   v_n;
    logic [3:0]       pending_n;
    logic [WIDTH-1:0] op_q [NCH];

    assign sel = {s2, s1, s0};

    // A full channel can still take a word when its consumer drains it in
    // the same cycle, so refill happens with no bubble.
    assign in_ready = ~v[sel] | ack[sel];

    // in_valid gates everything below; an undriven select while idle
    // therefore cannot reach any write enable.
    assign accept = in_valid & in_ready;

    // One-hot write enable decode of the select.
    always_comb begin
        wr_en = '0;
        if (accept) begin
            wr_en[sel] = 1'b1;
        end
    end

    // A drain only clears v when the same channel is not being refilled;
    // ack on an empty channel falls out because it is masked by v.
    assign drain = ack & v & ~wr_en;
    assign v_n   = (v & ~drain) | wr_en;

    // pending is registered from the next value of v so the two always
    // change on the same edge.
    always_comb begin
        pending_n = '0;
        for (int i = 0; i < NCH; i++) begin
            pending_n = pending_n + 4'(v_n[i]);
        end
    end

    // Per-channel data registers: load only on their own write enable,
    // otherwise hold the last value even after being drained.
    for (genvar g = 0; g < NCH; g++) begin : g_ch
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                op_q[g] <= '0;
            end else if (wr_en[g]) begin
                op_q[g] <= d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v       <= '0;
            pending <= '0;
        end else begin
            v       <= v_n;
            pending <= pending_n;
        end
    end

    assign op0 = op_q[0];
    assign op1 = op_q[1];
    assign op2 = op_q[2];
    assign op3 = op_q[3];
    assign op4 = op_q[4];
    assign op5 = op_q[5];
    assign op6 = op_q[6];
    assign op7 = op_q[7];

endmodule

// File: tb/tb_demux_1x8_32_buf.sv
// tb/tb_demux_1x8_32_buf.sv - directed scoreboard bench for demux_1x8_32_buf

module tb_demux_1x8_32_buf;

    logic        clk;
    logic        rst_n;
    logic [31:0] d;
    logic        s2, s1, s0;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op0, op1, op2, op3, op4, op5, op6, op7;
    logic [7:0]  v;
    logic [7:0]  ack;
    logic [3:0]  pending;

    demux_1x8_32_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d        (d),
        .s2       (s2),
        .s1       (s1),
        .s0       (s0),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op0      (op0),
        .op1      (op1),
        .op2      (op2),
        .op3      (op3),
        .op4      (op4),
        .op5      (op5),
        .op6      (op6),
        .op7      (op7),
        .v        (v),
        .ack      (ack),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mop [8];
    logic [7:0]  mv;
    logic [34:0] sb_q [$];   // {channel, data}

    function automatic logic [31:0] dut_op(input int ch);
        case (ch)
            0: return op0;
            1: return op1;
            2: return op2;
            3: return op3;
            4: return op4;
            5: return op5;
            6: return op6;
            default: return op7;
        endcase
    endfunction

    function automatic logic [3:0] model_count(input logic [7:0] vv);
        logic [3:0] c;
        c = 0;
        for (int i = 0; i < 8; i++) if (vv[i]) c = c + 1;
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".v"}, {24'h0, v}, {24'h0, mv});
        check({tag, ".pending"}, {28'h0, pending}, {28'h0, model_count(mv)});
        for (int i = 0; i < 8; i++)
            check($sformatf("%s.op%0d", tag, i), dut_op(i), mop[i]);
    endtask

    // One clock cycle: drive inputs, check in_ready against the model,
    // clock, update the model, retire any scoreboard entry.
    task automatic cycle(input string tag, input logic vld, input logic [2:0] sel,
                         input logic [31:0] data, input logic [7:0] ak);
        logic       exp_ready;
        logic       acc;
        logic [7:0] nv;
        logic [34:0] e;
        in_valid = vld;
        {s2, s1, s0} = sel;
        d   = data;
        ack = ak;
        #1;
        exp_ready = ~mv[sel] | ak[sel];
        check({tag, ".in_ready"}, {31'h0, in_ready}, {31'h0, exp_ready});
        acc = vld & exp_ready;
        if (acc) sb_q.push_back({sel, data});
        @(posedge clk);
        nv = mv & ~ak;
        if (acc) begin
            nv[sel]  = 1'b1;
            mop[sel] = data;
        end
        mv = nv;
        #1;
        if (acc) begin
            e = sb_q.pop_front();
            check({tag, ".sb_data"}, dut_op(int'(e[34:32])), e[31:0]);
            check({tag, ".sb_v"}, {31'h0, v[e[34:32]]}, 32'h1);
        end
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        {s2, s1, s0} = 3'b000;
        d = '0;
        ack = '0;
        mv = '0;
        for (int i = 0; i < 8; i++) mop[i] = '0;

        // Reset state
        #12;
        check("reset.in_ready", {31'h0, in_ready}, 32'h1);
        check_all("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single write to channel 5
        cycle("single", 1'b1, 3'b101, 32'hDEADBEEF, 8'h00);
        check("single.v_const", {24'h0, v}, 32'h20);
        check("single.pend_const", {28'h0, pending}, 32'h1);

        // Back-pressure on channel 2
        cycle("bp_fill", 1'b1, 3'b010, 32'hAAAA0002, 8'h00);
        cycle("bp_stall", 1'b1, 3'b010, 32'h12345678, 8'h00);
        check("bp_stall.op2", op2, 32'hAAAA0002);
        cycle("bp_pass", 1'b1, 3'b010, 32'h12345678, 8'h04);
        check("bp_pass.op2", op2, 32'h12345678);
        check("bp_pass.pending", {28'h0, pending}, 32'h2);

        // Drain everything, then spurious acks on empty channels
        cycle("drain", 1'b0, 3'b000, 32'h0, 8'hFF);
        check("drain.v_const", {24'h0, v}, 32'h0);
        cycle("spurious", 1'b0, 3'b011, 32'h5555AAAA, 8'hFF);
        check("spurious.op5", op5, 32'hDEADBEEF);

        // Idle cycles with the select wandering: no state change
        for (int i = 0; i < 4; i++)
            cycle("idle", 1'b0, 3'($urandom_range(0, 7)), $urandom, 8'h00);

        // Fill all channels
        for (int n = 0; n < 8; n++) begin
            cycle($sformatf("fill%0d", n), 1'b1, 3'(n), 32'h100 + n, 8'h00);
            check($sformatf("fill%0d.pend_const", n), {28'h0, pending}, n + 1);
        end
        check("fill.v_const", {24'h0, v}, 32'hFF);

        // 9th write stalls on every channel
        for (int n = 0; n < 8; n++)
            cycle($sformatf("full%0d", n), 1'b1, 3'(n), 32'hBAD0_0000 + n, 8'h00);

        // Mass drain plus accept to channel 0
        cycle("mass", 1'b1, 3'b000, 32'hCAFEF00D, 8'hFF);
        check("mass.v_const", {24'h0, v}, 32'h01);
        check("mass.op0", op0, 32'hCAFEF00D);
        check("mass.pend_const", {28'h0, pending}, 32'h1);

        // Refill, then reset mid-cycle with v full
        for (int n = 1; n < 8; n++)
            cycle($sformatf("refill%0d", n), 1'b1, 3'(n), 32'h200 + n, 8'h00);
        check("refill.v_const", {24'h0, v}, 32'hFF);
        in_valid = 1'b0;
        ack = '0;
        #2 rst_n = 1'b0;
        #1;
        mv = '0;
        for (int i = 0; i < 8; i++) mop[i] = '0;
        check("async_rst.in_ready", {31'h0, in_ready}, 32'h1);
        check_all("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle("post_rst", 1'b1, 3'b110, 32'h0BADCAFE, 8'h00);

        check("sb_empty", sb_q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
